wb_gain_apply: RTL and testbench



---
 rtl/wb_gain_apply.sv | 170 +++++++++++++++++
 tb/tb_wb_gain_apply.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_gain_apply.sv
// White-balance gain application: B/R pixels scaled by frame-synchronous gains, G bypassed,
// saturated pixels counted per frame. Optional macro WB_GAIN_ROUND_EN selects round-half-up.
module wb_gain_apply #(
    parameter int SAT_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 data_in_valid,
    input  logic [7:0]           data_in,
    input  logic                 x,
    input  logic                 y,
    input  logic                 sof,
    input  logic [17:0]          bk,
    input  logic [17:0]          rk,
    input  logic                 gain_valid,
    output logic [7:0]           data_out,
    output logic                 out_valid,
    output logic                 out_x,
    output logic                 out_y,
    output logic                 out_sof,
    output logic [SAT_CNT_W-1:0] sat_cnt_last
);

    // Handshake: data_in_valid qualifies a pixel every cycle it is high; there is no ready,
    // so the block accepts one pixel per cycle and out_valid follows two cycles later.

    localparam logic [17:0] UNITY = 18'd256;

    logic [17:0] pend_bk;
    logic [17:0] pend_rk;
    logic        pend_flag;
    logic [17:0] act_bk;
    logic [17:0] act_rk;

    logic        sof_acc;
    logic        take_pend;
    logic        is_b;
    logic        is_r;
    logic [17:0] use_bk;
    logic [17:0] use_rk;
    logic [17:0] gain_sel;
    logic [25:0] prod_in;

    logic        s1_valid;
    logic [25:0] s1_prod;
    logic        s1_x;
    logic        s1_y;
    logic        s1_sof;

    logic        res_sat;
    logic [7:0]  res_pix;
    logic        out_sat;

    logic [SAT_CNT_W-1:0] sat_cnt;

    assign sof_acc   = data_in_valid & sof;
    assign take_pend = sof_acc & pend_flag;
    assign is_b      = ~x & ~y;
    assign is_r      = x & y;

    // The sof pixel already sees the gains that are being promoted this cycle.
    assign use_bk = take_pend ? pend_bk : act_bk;
    assign use_rk = take_pend ? pend_rk : act_rk;

    // Green goes through the multiplier at unity, which reproduces the pixel exactly
    // (also with rounding) and can never saturate.
    always_comb begin
        gain_sel = UNITY;
        if (is_b) begin
            gain_sel = use_bk;
        end else if (is_r) begin
            gain_sel = use_rk;
        end
    end

    assign prod_in = {18'd0, data_in} * {8'd0, gain_sel};

    // Gain double buffering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_bk   <= UNITY;
            pend_rk   <= UNITY;
            pend_flag <= 1'b0;
            act_bk    <= UNITY;
            act_rk    <= UNITY;
        end else begin
            if (gain_valid) begin
                pend_bk   <= bk;
                pend_rk   <= rk;
                pend_flag <= 1'b1;
            end else if (take_pend) begin
                pend_flag <= 1'b0;
            end
            if (take_pend) begin
                act_bk <= pend_bk;
                act_rk <= pend_rk;
            end
        end
    end

    // Stage 1: product register; data fields hold during bubbles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_prod  <= '0;
            s1_x     <= 1'b0;
            s1_y     <= 1'b0;
            s1_sof   <= 1'b0;
        end else begin
            s1_valid <= data_in_valid;
            if (data_in_valid) begin
                s1_prod <= prod_in;
                s1_x    <= x;
                s1_y    <= y;
                s1_sof  <= sof;
            end
        end
    end

`ifdef WB_GAIN_ROUND_EN
    logic [26:0] rnd_sum;
    logic [18:0] rnd_res;
    assign rnd_sum = {1'b0, s1_prod} + 27'd128;
    assign rnd_res = 19'(rnd_sum >> 8);
    assign res_sat = |rnd_res[18:8];
    assign res_pix = res_sat ? 8'hFF : rnd_res[7:0];
`else
    logic [17:0] trn_res;
    assign trn_res = 18'(s1_prod >> 8);
    assign res_sat = |trn_res[17:8];
    assign res_pix = res_sat ? 8'hFF : trn_res[7:0];
`endif

    // Stage 2: output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            data_out  <= 8'd0;
            out_x     <= 1'b0;
            out_y     <= 1'b0;
            out_sof   <= 1'b0;
            out_sat   <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                data_out <= res_pix;
                out_x    <= s1_x;
                out_y    <= s1_y;
                out_sof  <= s1_sof;
                out_sat  <= res_sat;
            end
        end
    end

    // Per-frame saturation count; the sof pixel belongs to the new frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_cnt      <= '0;
            sat_cnt_last <= '0;
        end else if (out_valid) begin
            if (out_sof) begin
                sat_cnt_last <= sat_cnt;
                sat_cnt      <= {{(SAT_CNT_W-1){1'b0}}, out_sat};
            end else if (out_sat && (sat_cnt != {SAT_CNT_W{1'b1}})) begin
                sat_cnt <= sat_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_gain_apply.sv
// Bench for wb_gain_apply: vector table plus hand sequences for gain switching and reset,
// checked through an expected-output queue.
module tb_wb_gain_apply;

  logic        clk;
  logic        rst;
  logic        data_in_valid;
  logic [7:0]  data_in;
  logic        x;
  logic        y;
  logic        sof;
  logic [17:0] bk;
  logic [17:0] rk;
  logic        gain_valid;
  logic [7:0]  data_out;
  logic        out_valid;
  logic        out_x;
  logic        out_y;
  logic        out_sof;
  logic [15:0] sat_cnt_last;

  int n_chk = 0;
  int n_fail = 0;

  // {x, y, sof, data}
  logic [10:0] exp_q[$];

`ifdef WB_GAIN_ROUND_EN
  localparam logic [7:0] E101 = 8'd152;
`else
  localparam logic [7:0] E101 = 8'd151;
`endif

  typedef struct {
    logic        v;
    logic        xx;
    logic        yy;
    logic        s;
    logic        gv;
    logic [17:0] b;
    logic [17:0] r;
    logic [7:0]  p;
    logic [7:0]  e;
    logic        chk;
    logic [15:0] last;
  } vec_t;

  vec_t tbl[17];

  wb_gain_apply #(.SAT_CNT_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .data_in_valid(data_in_valid),
    .data_in(data_in),
    .x(x),
    .y(y),
    .sof(sof),
    .bk(bk),
    .rk(rk),
    .gain_valid(gain_valid),
    .data_out(data_out),
    .out_valid(out_valid),
    .out_x(out_x),
    .out_y(out_y),
    .out_sof(out_sof),
    .sat_cnt_last(sat_cnt_last)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic xx, input logic yy, input logic s,
                              input logic gv, input logic [17:0] b, input logic [17:0] r,
                              input logic [7:0] p, input logic [7:0] e, input logic chk,
                              input logic [15:0] last);
    vec_t t;
    t.v = v; t.xx = xx; t.yy = yy; t.s = s; t.gv = gv;
    t.b = b; t.r = r; t.p = p; t.e = e; t.chk = chk; t.last = last;
    return t;
  endfunction

  // Reference for the random phase: pixel times gain, optional rounding, clip to 255.
  function automatic logic [7:0] model(input logic [7:0] p, input logic [17:0] g);
    logic [26:0] t;
    t = 27'(p) * 27'(g);
`ifdef WB_GAIN_ROUND_EN
    t = t + 27'd128;
`endif
    t = t >> 8;
    return (t > 27'd255) ? 8'hFF : t[7:0];
  endfunction

  // driver tasks
  task automatic drive(input logic v, input logic xx, input logic yy, input logic s,
                       input logic gv, input logic [17:0] b, input logic [17:0] r,
                       input logic [7:0] p, input logic [7:0] e);
    @(negedge clk);
    data_in_valid = v;
    x = xx;
    y = yy;
    sof = s;
    gain_valid = gv;
    bk = b;
    rk = r;
    data_in = p;
    if (v) exp_q.push_back({xx, yy, s, e});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      data_in_valid = 1'b0;
      sof = 1'b0;
      gain_valid = 1'b0;
    end
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        check("pixel_out", 32'({out_x, out_y, out_sof, data_out}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [17:0] gsel;
    logic        rv, rx, ry;
    logic [7:0]  rp;

    rst = 1'b0;
    data_in_valid = 1'b0;
    data_in = 8'd0;
    x = 1'b0;
    y = 1'b0;
    sof = 1'b0;
    bk = 18'd0;
    rk = 18'd0;
    gain_valid = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_phase_sof", 32'({out_x, out_y, out_sof}), 32'd0);
    check("rst_sat_cnt_last", 32'(sat_cnt_last), 32'd0);
    rst = 1'b1;
    idle(2);

    // v xx yy s gv bk rk pix exp chk last
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 18'd0,   18'd0,   8'd77,  8'd77,  1'b0, 16'd0);
    tbl[1]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 18'd0,   18'd0,   8'd200, 8'd200, 1'b1, 16'd0);
    tbl[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 18'd384, 18'd512, 8'd0,   8'd0,   1'b0, 16'd0);
    tbl[3]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 18'd0,   18'd0,   8'd100, 8'd150, 1'b0, 16'd0);
    tbl[4]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 18'd0,   18'd0,   8'd100, 8'd200, 1'b0, 16'd0);
    tbl[5]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 18'd0,   18'd0,   8'd100, 8'd100, 1'b0, 16'd0);
    tbl[6]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 18'd0,   18'd0,   8'd200, 8'd255, 1'b0, 16'd0);
    tbl[7]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 18'd0,   18'd0,   8'd200, 8'd255, 1'b0, 16'd0);
    tbl[8]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 18'd0,   18'd0,   8'd200, 8'd255, 1'b0, 16'd0);
    tbl[9]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 18'd0,   18'd0,   8'd101, E101,   1'b0, 16'd0);
    tbl[10] = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 18'd0,   18'd0,   8'd200, 8'd255, 1'b1, 16'd3);
    tbl[11] = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 18'd0,   18'd0,   8'd255, 8'd255, 1'b0, 16'd0);
    tbl[12] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 18'd0,   18'd0,   8'd255, 8'd255, 1'b0, 16'd0);
    tbl[13] = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 18'd0,   18'd0,   8'd0,   8'd0,   1'b1, 16'd2);
    tbl[14] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 18'd0,   18'd0,   8'd0,   8'd0,   1'b0, 16'd0);
    tbl[15] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 18'd0,   18'd0,   8'd200, 8'd0,   1'b0, 16'd0);
    tbl[16] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 18'd0,   18'd0,   8'd255, 8'd0,   1'b1, 16'd0);

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].v, tbl[i].xx, tbl[i].yy, tbl[i].s, tbl[i].gv,
            tbl[i].b, tbl[i].r, tbl[i].p, tbl[i].e);
      if (tbl[i].chk) begin
        idle(5);
        check("sat_cnt_last", 32'(sat_cnt_last), 32'(tbl[i].last));
      end
    end

    // reset mid-stream: pending gains loaded, pixels in flight
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 18'd1024, 18'd1024, 8'd0, 8'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 18'd0, 18'd0, 8'd10, 8'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 18'd0, 18'd0, 8'd11, 8'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 18'd0, 18'd0, 8'd12, 8'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_data_out", 32'(data_out), 32'd0);
    check("midrst_sat_cnt_last", 32'(sat_cnt_last), 32'd0);
    exp_q.delete();
    data_in_valid = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(1);
    // pending 1024 was lost: the sof pixel stays at unity
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 18'd0, 18'd0, 8'd77, 8'd77);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 18'd0, 18'd0, 8'd90, 8'd90);

    // mid-frame gain update waits for the next sof
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 18'd0,   18'd0,   8'd50, 8'd50);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 18'd512, 18'd512, 8'd50, 8'd50);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 18'd0,   18'd0,   8'd50, 8'd50);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 18'd0,   18'd0,   8'd50, 8'd100);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 18'd0,   18'd0,   8'd50, 8'd100);

    // gain_valid coincident with sof while pending: old pending applied, new stays pending
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 18'd640, 18'd640, 8'd0,   8'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 18'd512, 18'd512, 8'd100, 8'd250);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 18'd0,   18'd0,   8'd100, 8'd250);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 18'd0,   18'd0,   8'd100, 8'd200);
    // gain_valid coincident with sof, nothing pending: pixel keeps active gains
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 18'd256, 18'd768, 8'd100, 8'd200);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 18'd0,   18'd0,   8'd100, 8'd200);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 18'd0,   18'd0,   8'd100, 8'd100);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 18'd0,   18'd0,   8'd60,  8'd180);

    // random pixels with bubbles; active gains are bk=256, rk=768
    for (int i = 0; i < 60; i++) begin
      rv = ($urandom_range(3) != 0);
      rx = 1'($urandom_range(1));
      ry = 1'($urandom_range(1));
      rp = 8'($urandom_range(255));
      gsel = (!rx && !ry) ? 18'd256 : ((rx && ry) ? 18'd768 : 18'd256);
      drive(rv, rx, ry, 1'b0, 1'b0, 18'd0, 18'd0, rp, model(rp, gsel));
    end

    idle(1);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
